// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch sequencing controller: decodes start/stop/lap/clear commands and
// generates the prescaled count tick, counter clear, lap capture and display
// freeze controls. All outputs are registered.
module stopwatch_lap_ctrl #(
   parameter int unsigned TICK_DIV   = 1000000,
   parameter int unsigned HOLD_TICKS = 300,
   parameter int unsigned LAP_W      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             lap_i,
   input  logic             clear_i,
   output logic             tick_o,
   output logic             counter_clr_o,
   output logic             lap_capture_o,
   output logic             disp_freeze_o,
   output logic [LAP_W-1:0] lap_count_o,
   output logic [1:0]       state_out_o
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned HW = $clog2(HOLD_TICKS + 1);

   localparam logic [PW-1:0]    PrescMax = PW'(TICK_DIV - 1);
   localparam logic [HW-1:0]    HoldLast = HW'(HOLD_TICKS - 1);
   localparam logic [LAP_W-1:0] LapMax   = {LAP_W{1'b1}};

   typedef enum logic [1:0] {
      StIdle    = 2'b00,
      StRunning = 2'b01,
      StPaused  = 2'b10,
      StLapHold = 2'b11
   } state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;
   logic             tick_q, tick_d;
   logic             clr_q, clr_d;
   logic             cap_q, cap_d;
   logic             freeze_q, freeze_d;

   logic cmd_stop, cmd_start, cmd_lap;
   logic counting, wrap;

   // Command priority decode and prescaler / tick generation
   always_comb begin
      cmd_stop  = stop_i & ~clear_i;
      cmd_start = start_i & ~clear_i & ~stop_i;
      cmd_lap   = lap_i & ~clear_i & ~stop_i & ~start_i;
      // Stop or clear in the wrap cycle suppresses that tick
      counting  = ((state_q == StRunning) || (state_q == StLapHold)) & ~clear_i & ~stop_i;
      wrap      = counting && (presc_q == PrescMax);
      tick_d    = wrap;
      presc_d   = presc_q;
      if (clear_i) begin
         presc_d = '0;
      end else if (counting) begin
         presc_d = wrap ? '0 : presc_q + 1'b1;
      end
   end

   // Next-state, hold timer, lap counter and strobe outputs
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      lap_cnt_d = lap_cnt_q;
      cap_d     = 1'b0;
      clr_d     = 1'b0;
      if (clear_i) begin
         state_d   = StIdle;
         clr_d     = 1'b1;
         lap_cnt_d = '0;
         hold_d    = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (cmd_start) state_d = StRunning;
            end
            StRunning: begin
               if (cmd_stop) begin
                  state_d = StPaused;
               end else if (cmd_lap) begin
                  state_d = StLapHold;
                  cap_d   = 1'b1;
                  hold_d  = '0;
                  if (lap_cnt_q != LapMax) lap_cnt_d = lap_cnt_q + 1'b1;
               end
            end
            StPaused: begin
               if (cmd_start) state_d = StRunning;
            end
            StLapHold: begin
               if (cmd_stop) begin
                  state_d = StPaused;
               end else if (cmd_start) begin
                  state_d = StRunning;
               end else if (cmd_lap) begin
                  // A lap in the expiry cycle restarts the hold
                  cap_d  = 1'b1;
                  hold_d = '0;
                  if (lap_cnt_q != LapMax) lap_cnt_d = lap_cnt_q + 1'b1;
               end else if (wrap) begin
                  if (hold_q == HoldLast) begin
                     state_d = StRunning;
                  end else begin
                     hold_d = hold_q + 1'b1;
                  end
               end
            end
         endcase
      end
      freeze_d = (state_d == StLapHold);
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         presc_q   <= '0;
         hold_q    <= '0;
         lap_cnt_q <= '0;
         tick_q    <= 1'b0;
         clr_q     <= 1'b0;
         cap_q     <= 1'b0;
         freeze_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         hold_q    <= hold_d;
         lap_cnt_q <= lap_cnt_d;
         tick_q    <= tick_d;
         clr_q     <= clr_d;
         cap_q     <= cap_d;
         freeze_q  <= freeze_d;
      end
   end

   assign tick_o        = tick_q;
   assign counter_clr_o = clr_q;
   assign lap_capture_o = cap_q;
   assign disp_freeze_o = freeze_q;
   assign lap_count_o   = lap_cnt_q;
   assign state_out_o   = state_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed table-driven bench for stopwatch_lap_ctrl (TICK_DIV=4, HOLD_TICKS=3, LAP_W=2).
module tb_stopwatch_lap_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, stop, lap, clear;
   logic       tick, counter_clr, lap_capture, disp_freeze;
   logic [1:0] lap_count;
   logic [1:0] state_out;

   int errors = 0;
   int checks = 0;

   // cmd = {start, stop, lap, clear}
   // exp = {tick, counter_clr, lap_capture, disp_freeze, lap_count[1:0], state[1:0]}
   typedef struct {
      logic [3:0] cmd;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs[$];

   stopwatch_lap_ctrl #(
      .TICK_DIV  (4),
      .HOLD_TICKS(3),
      .LAP_W     (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start_i      (start),
      .stop_i       (stop),
      .lap_i        (lap),
      .clear_i      (clear),
      .tick_o       (tick),
      .counter_clr_o(counter_clr),
      .lap_capture_o(lap_capture),
      .disp_freeze_o(disp_freeze),
      .lap_count_o  (lap_count),
      .state_out_o  (state_out)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] outs();
      return {tick, counter_clr, lap_capture, disp_freeze, lap_count, state_out};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b required %b (tick,clr,cap,frz,lc,st)", name, act, exp);
      end
   endtask

   task automatic add(input logic [3:0] cmd, input logic [7:0] exp);
      vec_t v;
      v.cmd = cmd;
      v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [3:0] cmd);
      {start, stop, lap, clear} = cmd;
   endtask

   initial begin
      // Test 1: start, stop/lap ignored in IDLE, tick every 4 cycles
      add(4'b0000, 8'b0000_00_00);
      add(4'b0100, 8'b0000_00_00);
      add(4'b0010, 8'b0000_00_00);
      add(4'b1000, 8'b0000_00_01);
      repeat (3) add(4'b0000, 8'b0000_00_01);
      add(4'b0000, 8'b1000_00_01);
      repeat (3) add(4'b0000, 8'b0000_00_01);
      add(4'b0000, 8'b1000_00_01);
      repeat (2) add(4'b0000, 8'b0000_00_01);
      // Test 2: pause two cycles into a period, lap ignored, resume completes period
      add(4'b0100, 8'b0000_00_10);
      repeat (3) add(4'b0000, 8'b0000_00_10);
      add(4'b0010, 8'b0000_00_10);
      add(4'b1000, 8'b0000_00_01);
      add(4'b0000, 8'b0000_00_01);
      add(4'b0000, 8'b1000_00_01);
      add(4'b0000, 8'b0000_00_01);
      // Test 3: lap, hold for 3 ticks, auto-release
      add(4'b0010, 8'b0011_01_11);
      add(4'b0000, 8'b0001_01_11);
      add(4'b0000, 8'b1001_01_11);
      repeat (3) add(4'b0000, 8'b0001_01_11);
      add(4'b0000, 8'b1001_01_11);
      repeat (3) add(4'b0000, 8'b0001_01_11);
      add(4'b0000, 8'b1000_01_01);
      // Test 4: five laps, saturation, lap in expiry cycle
      add(4'b0010, 8'b0011_10_11);
      add(4'b0010, 8'b0011_11_11);
      add(4'b0010, 8'b0011_11_11);
      add(4'b0010, 8'b1011_11_11);
      add(4'b0010, 8'b0011_11_11);
      repeat (2) add(4'b0000, 8'b0001_11_11);
      add(4'b0000, 8'b1001_11_11);
      repeat (3) add(4'b0000, 8'b0001_11_11);
      add(4'b0000, 8'b1001_11_11);
      repeat (3) add(4'b0000, 8'b0001_11_11);
      add(4'b0010, 8'b1011_11_11);
      // Stop and start out of LAP_HOLD
      add(4'b0100, 8'b0000_11_10);
      add(4'b1000, 8'b0000_11_01);
      add(4'b0000, 8'b0000_11_01);
      add(4'b0010, 8'b0011_11_11);
      add(4'b1000, 8'b0000_11_01);
      // Test 5: start+stop+lap in wrap cycle -> pause, tick suppressed; clear+start
      add(4'b1110, 8'b0000_11_10);
      add(4'b1000, 8'b0000_11_01);
      add(4'b1001, 8'b0100_00_00);
      add(4'b0000, 8'b0000_00_00);
      // Prescaler restarts from zero after clear
      add(4'b1000, 8'b0000_00_01);
      repeat (3) add(4'b0000, 8'b0000_00_01);
      add(4'b0000, 8'b1000_00_01);
      add(4'b0010, 8'b0011_01_11);

      rst = 1'b1;
      drive(4'b0000);
      #1;
      check("reset_state", outs(), 8'b0000_00_00);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].cmd);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), outs(), vecs[i].exp);
         @(negedge clk);
      end
      drive(4'b0000);

      // Test 6: asynchronous reset between edges while in LAP_HOLD
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_rst", outs(), 8'b0000_00_00);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("idle_after_rst", outs(), 8'b0000_00_00);
      drive(4'b1000);
      @(posedge clk);
      #1;
      check("start_after_rst", outs(), 8'b0000_00_01);
      @(negedge clk);
      drive(4'b0000);
      repeat (3) @(negedge clk);
      check("presc_zero_pre", outs(), 8'b0000_00_01);
      @(posedge clk);
      #1;
      check("tick_after_rst", outs(), 8'b1000_00_01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stopwatch_lap_ctrl.md
Name: stopwatch_lap_ctrl

Overview:
Sequencing controller for the stopwatch time-counter datapath. It decodes single-cycle start/stop/lap/clear commands and generates the prescaled count tick that advances the time counter. It also generates the counter clear pulse and the lap-capture/display-freeze controls for the split-time register and display path. It sits between the button front end (pulses already debounced and synchronised) and the time counter, lap register and display mux.

Parameters:
TICK_DIV, 1000000, clk cycles per count tick (e.g. 10 ms at 100 MHz); must be >= 2
HOLD_TICKS, 300, ticks the display stays frozen after a lap before auto-release; must be >= 1
LAP_W, 4, width of lap counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  start/resume command, one-cycle pulse
stop  in  1  pause command, one-cycle pulse
lap  in  1  lap/split command, one-cycle pulse
clear  in  1  clear-to-zero command, one-cycle pulse
tick  out  1  one-cycle count enable to time counter
counter_clr  out  1  one-cycle synchronous clear to time counter
lap_capture  out  1  one-cycle load strobe to lap register
disp_freeze  out  1  display shows lap register while high
lap_count  out  LAP_W  number of laps taken, saturating
state_out  out  2  current state encoding

Behaviour:
- One clock, asynchronous active-high reset rst. While rst is high: state IDLE, all outputs 0, prescaler, hold timer and lap_count 0.
- All outputs are registered. Commands sampled at edge k take effect on outputs after edge k, so latency is 1 cycle.
- States (state_out): IDLE 00, RUNNING 01, PAUSED 10, LAP_HOLD 11.
- Command priority in one cycle: clear > stop > start > lap. A lower-priority command in the same cycle is dropped.
- clear (any state): go to IDLE; counter_clr=1 for 1 cycle; lap_count, prescaler and hold timer go to 0; disp_freeze=0.
- IDLE: start -> RUNNING. stop and lap are ignored.
- RUNNING: stop -> PAUSED. lap -> LAP_HOLD with lap_capture=1 for 1 cycle, disp_freeze=1, hold timer=0, lap_count+1.
- LAP_HOLD: lap -> stay in LAP_HOLD, lap_capture pulse, hold timer=0, lap_count+1. start -> RUNNING, disp_freeze=0. stop -> PAUSED, disp_freeze=0.
- LAP_HOLD auto-release: when a tick is issued with hold timer == HOLD_TICKS-1, go to RUNNING with disp_freeze=0. If lap arrives in the expiry cycle, lap wins and the hold restarts.
- PAUSED: start -> RUNNING. lap is ignored.
- lap_count saturates at 2^LAP_W-1. lap_capture still pulses when saturated.
- Prescaler range 0..TICK_DIV-1. It advances only in cycles where the state is RUNNING or LAP_HOLD and no stop/clear is sampled.
- Tick generation: at prescaler == TICK_DIV-1 the prescaler wraps to 0 and tick=1 on the next cycle. tick runs uninterrupted through LAP_HOLD entry and exit.
- PAUSED retains the prescaler value, so resume completes the partial period. A stop sampled in the wrap cycle suppresses that tick.
- Hold timer counts issued ticks only while in LAP_HOLD.
- counter_clr and tick are never high in the same cycle.
- Asserting rst mid-operation (any state) forces outputs to 0 immediately, without waiting for a clock edge.

Test Plan:
Use TICK_DIV=4, HOLD_TICKS=3, LAP_W=2 for all scenarios.
1. Release rst, pulse start -> state_out=01 next cycle; tick high 1 cycle every 4 cycles, first tick 4 cycles after start is sampled.
2. Pulse stop 2 counting cycles into a period, idle 10 cycles, pulse start -> state_out 10 then 01; no ticks while paused; next tick after 2 more counting cycles.
3. Pulse lap while RUNNING -> lap_capture=1 for 1 cycle, state_out=11, disp_freeze=1, lap_count=1; after 3 ticks state_out=01, disp_freeze=0; tick period stays 4 throughout.
4. Pulse lap 5 times in LAP_HOLD -> lap_capture pulses 5 times, lap_count stops at 3; lap in the expiry cycle keeps state_out=11.
5. In RUNNING, pulse start+stop+lap in the same cycle -> state_out=10, no lap_capture. Then pulse clear+start -> state_out=00, counter_clr=1 for 1 cycle, lap_count=0, no tick.
6. Assert rst between clock edges in LAP_HOLD -> state_out=00, disp_freeze=0, lap_count=0 before the next edge. Deassert rst -> stays IDLE until start.
